// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver. The parity state exists only
// when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int UART_DEFAULT_DIV = 2604;
   localparam int UART_MIN_DIV     = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with first-word fall-through and a zero head when empty. If the FIFO
// is full, a push is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_pop;
   logic             w_write;

   assign empty   = (r_count == '0);
   assign full    = (r_count == FULL_CNT);
   assign w_pop   = pop & ~empty;
   assign w_write = push & (~full | w_pop);
   assign head    = empty ? '0 : r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_write) r_mem[r_wptr] <= wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_write) r_wptr <= r_wptr + AW'(1);
         if (w_pop)   r_rptr <= r_rptr + AW'(1);
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with a programmable divisor, a receive FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int BAUD_W     = 13,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 RX,
   input  logic [BAUD_W-1:0]    baud_div,
   input  logic                 rd_en,
   input  logic                 clr_err,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rdy,
   output logic                 overrun,
   output logic                 frame_err,
   output logic                 parity_err
);

   rx_state_t            r_state, w_nextState;
   logic                 r_sync1, r_sync2, r_hist;
   logic [BAUD_W-1:0]    r_cnt, r_div, w_divEff;
   logic [3:0]           r_bitCnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_overrun, r_frameErr;
   logic                 w_rx, w_startEdge, w_tick;
   logic                 w_loadStart, w_reload, w_shiftEn;
   logic                 w_push, w_frameErrSet, w_overrunSet;
   logic                 w_full, w_empty;

   assign w_rx        = r_sync2;
   assign w_startEdge = r_hist & ~r_sync2;
   assign w_tick      = (r_cnt == '0);
   assign w_divEff    = (baud_div < BAUD_W'(UART_MIN_DIV)) ? BAUD_W'(UART_MIN_DIV) : baud_div;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_hist  <= 1'b1;
         r_state <= S_IDLE;
      end else begin
         r_sync1 <= RX;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
         r_state <= w_nextState;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_parBad, r_parityErr, w_parityErrSet;
   assign parity_err = r_parityErr;
`else
   assign parity_err = 1'b0;
`endif

   always_comb begin
      w_nextState   = r_state;
      w_loadStart   = 1'b0;
      w_reload      = 1'b0;
      w_shiftEn     = 1'b0;
      w_push        = 1'b0;
      w_frameErrSet = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_parityErrSet = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_startEdge) begin
               w_nextState = S_START;
               w_loadStart = 1'b1;
            end
         end
         S_START: begin
            if (w_tick) begin
               if (w_rx) begin
                  w_nextState = S_IDLE;
               end else begin
                  w_nextState = S_DATA;
                  w_reload    = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (w_tick) begin
               w_reload  = 1'b1;
               w_shiftEn = 1'b1;
               if (r_bitCnt == 4'(DATA_BITS-1)) begin
`ifdef UART_RX_PARITY_EN
                  w_nextState = S_PARITY;
`else
                  w_nextState = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_tick) begin
               w_reload       = 1'b1;
               w_parityErrSet = (w_rx != ^r_shift);
               w_nextState    = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (w_tick) begin
               w_nextState = S_IDLE;
               if (!w_rx) begin
                  w_frameErrSet = 1'b1;
               end else begin
`ifdef UART_RX_PARITY_EN
                  w_push = ~r_parBad;
`else
                  w_push = 1'b1;
`endif
               end
            end
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // Divisor is captured at the start edge so a mid-frame change of baud_div is harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_div    <= '0;
         r_bitCnt <= '0;
         r_shift  <= '0;
      end else begin
         if (w_loadStart) begin
            r_cnt    <= w_divEff >> 1;
            r_div    <= w_divEff;
            r_bitCnt <= '0;
         end else if (w_reload) begin
            r_cnt <= r_div - BAUD_W'(1);
         end else if (r_state != S_IDLE && !w_tick) begin
            r_cnt <= r_cnt - BAUD_W'(1);
         end
         if (w_shiftEn) begin
            r_shift  <= {w_rx, r_shift[DATA_BITS-1:1]};
            r_bitCnt <= r_bitCnt + 4'd1;
         end
      end
   end

   assign w_overrunSet = w_push & w_full & ~rd_en;

   // A flag being set in the same cycle as clr_err stays set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun  <= 1'b0;
         r_frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parBad    <= 1'b0;
         r_parityErr <= 1'b0;
`endif
      end else begin
         if (w_overrunSet)       r_overrun <= 1'b1;
         else if (clr_err)       r_overrun <= 1'b0;
         if (w_frameErrSet)      r_frameErr <= 1'b1;
         else if (clr_err)       r_frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
         if (w_loadStart)        r_parBad <= 1'b0;
         else if (w_parityErrSet) r_parBad <= 1'b1;
         if (w_parityErrSet)     r_parityErr <= 1'b1;
         else if (clr_err)       r_parityErr <= 1'b0;
`endif
      end
   end

   uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (rd_en),
      .wdata (r_shift),
      .full  (w_full),
      .empty (w_empty),
      .head  (rx_data)
   );

   assign rdy       = ~w_empty;
   assign overrun   = r_overrun;
   assign frame_err = r_frameErr;

endmodule
